// File: rtl/coin_acceptor.sv
// Coin pulse-width classifier: measures coin_in high time and emits a one-clock coin code, reject or jam.
// Optional macro COIN_SYNC_EN adds a two-flop synchronizer on coin_in (2 clocks extra latency).
module coin_acceptor #(
    parameter int SHORT_MIN = 4,
    parameter int SHORT_MAX = 15,
    parameter int LONG_MIN  = 16,
    parameter int LONG_MAX  = 40,
    parameter int GAP       = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       coin_in,
    output logic [1:0] dout,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam int HOLD_W = $clog2(GAP + 1);

    localparam logic [CNT_W-1:0]  S_MIN    = CNT_W'(SHORT_MIN);
    localparam logic [CNT_W-1:0]  S_MAX    = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0]  L_MIN    = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0]  L_MAX    = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0]  W_SAT    = {CNT_W{1'b1}};
    localparam logic [HOLD_W-1:0] GAP_LAST = HOLD_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        JAM     = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  w, w_nxt;
    logic [HOLD_W-1:0] hcnt, hcnt_nxt;
    logic [1:0]        dout_nxt;
    logic              reject_nxt;
    logic              jam_nxt;
    logic              coin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == W_SAT) ? v : v + CNT_W'(1);
    endfunction

    // Returns {reject, dout}; the short range wins where ranges overlap.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] v);
        if (v >= S_MIN && v <= S_MAX)
            return 3'b010;
        else if (v >= L_MIN && v <= L_MAX)
            return 3'b011;
        else
            return 3'b100;
    endfunction

`ifdef COIN_SYNC_EN
    logic coin_p0, coin_p1;

    // Synchronizer stages p0 -> p1
    always_ff @(posedge clock) begin
        if (rst) begin
            coin_p0 <= 1'b0;
            coin_p1 <= 1'b0;
        end else begin
            coin_p0 <= coin_in;
            coin_p1 <= coin_p0;
        end
    end

    assign coin = coin_p1;
`else
    assign coin = coin_in;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= IDLE;
            w      <= '0;
            hcnt   <= '0;
            dout   <= 2'b00;
            reject <= 1'b0;
            jam    <= 1'b0;
        end else begin
            state  <= state_nxt;
            w      <= w_nxt;
            hcnt   <= hcnt_nxt;
            dout   <= dout_nxt;
            reject <= reject_nxt;
            jam    <= jam_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        w_nxt      = w;
        hcnt_nxt   = hcnt;
        dout_nxt   = 2'b00;
        reject_nxt = 1'b0;
        jam_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (coin) begin
                    state_nxt = MEASURE;
                    w_nxt     = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (coin) begin
                    // One more high sample would push W past LONG_MAX.
                    if (w >= L_MAX) begin
                        state_nxt = JAM;
                        jam_nxt   = 1'b1;
                    end else begin
                        w_nxt = sat_inc(w);
                    end
                end else begin
                    state_nxt              = HOLD;
                    hcnt_nxt               = '0;
                    {reject_nxt, dout_nxt} = classify(w);
                end
            end
            JAM: begin
                if (coin) begin
                    jam_nxt = 1'b1;
                end else begin
                    state_nxt  = HOLD;
                    hcnt_nxt   = '0;
                    reject_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (coin) begin
                    hcnt_nxt = '0;
                end else if (hcnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                    w_nxt     = '0;
                end else begin
                    hcnt_nxt = hcnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed-vector bench for coin_acceptor in its default configuration.
module tb_coin_acceptor;

    localparam int GAP = 8;

    logic       clock;
    logic       rst;
    logic       coin_in;
    logic [1:0] dout;
    logic       reject;
    logic       jam;
    logic       busy;

    int tests = 0;
    int fails = 0;

    coin_acceptor dut (
        .clock  (clock),
        .rst    (rst),
        .coin_in(coin_in),
        .dout   (dout),
        .reject (reject),
        .jam    (jam),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one sample, then return at the following falling edge when the
    // registered response to that sample is visible.
    task automatic cyc(input logic c);
        coin_in = c;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        tests++;
        if (dout !== 2'b00 || reject !== 1'b0 || jam !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: dout=%b reject=%b jam=%b busy=%b, want 00 0 0 0", dout, reject, jam, busy);
        end
        rst = 1'b0;
        cyc(1'b0);
        tests++;
        if (busy !== 1'b0 || dout !== 2'b00) begin
            fails++;
            $display("FAIL reset_release: dout=%b busy=%b, want 00 0", dout, busy);
        end
    endtask

    task automatic test_five_unit();
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL five_measure[%0d]: dout=%b reject=%b busy=%b, want 00 0 1", i, dout, reject, busy);
            end
        end
        cyc(1'b0);
        tests++;
        if (dout !== 2'b10 || reject !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL five_code: dout=%b reject=%b busy=%b, want 10 0 1", dout, reject, busy);
        end
        for (int k = 1; k <= GAP; k++) begin
            cyc(1'b0);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b0 || busy !== (k < GAP)) begin
                fails++;
                $display("FAIL five_hold[%0d]: dout=%b reject=%b busy=%b, want 00 0 %b", k, dout, reject, busy, k < GAP);
            end
        end
    endtask

    task automatic test_widths();
        int         w_tab [6] = '{20, 16, 40, 15, 4, 10};
        logic [1:0] c_tab [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
        for (int t = 0; t < 6; t++) begin
            repeat (w_tab[t]) cyc(1'b1);
            cyc(1'b0);
            tests++;
            if (dout !== c_tab[t] || reject !== 1'b0) begin
                fails++;
                $display("FAIL width_code[w=%0d]: dout=%b reject=%b, want %b 0", w_tab[t], dout, reject, c_tab[t]);
            end
            cyc(1'b0);
            tests++;
            if (dout !== 2'b00) begin
                fails++;
                $display("FAIL width_one_clock[w=%0d]: dout=%b, want 00", w_tab[t], dout);
            end
            repeat (GAP) cyc(1'b0);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL width_idle[w=%0d]: busy=%b, want 0", w_tab[t], busy);
            end
        end
    endtask

    task automatic test_reject();
        int w_tab [3] = '{2, 3, 1};
        for (int t = 0; t < 3; t++) begin
            repeat (w_tab[t]) cyc(1'b1);
            cyc(1'b0);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b1) begin
                fails++;
                $display("FAIL reject_pulse[w=%0d]: dout=%b reject=%b, want 00 1", w_tab[t], dout, reject);
            end
            cyc(1'b0);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b0) begin
                fails++;
                $display("FAIL reject_one_clock[w=%0d]: dout=%b reject=%b, want 00 0", w_tab[t], dout, reject);
            end
            repeat (GAP) cyc(1'b0);
        end
    endtask

    task automatic test_jam();
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b1);
            tests++;
            if (jam !== (i >= 41) || dout !== 2'b00 || reject !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL jam_level[%0d]: jam=%b dout=%b reject=%b busy=%b, want %b 00 0 1", i, jam, dout, reject, busy, i >= 41);
            end
        end
        cyc(1'b0);
        tests++;
        if (jam !== 1'b0 || reject !== 1'b1 || dout !== 2'b00 || busy !== 1'b1) begin
            fails++;
            $display("FAIL jam_release: jam=%b reject=%b dout=%b busy=%b, want 0 1 00 1", jam, reject, dout, busy);
        end
        cyc(1'b0);
        tests++;
        if (reject !== 1'b0 || dout !== 2'b00) begin
            fails++;
            $display("FAIL jam_after: reject=%b dout=%b, want 0 00", reject, dout);
        end
        repeat (GAP) cyc(1'b0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL jam_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_hold_restart();
        repeat (10) cyc(1'b1);
        cyc(1'b0);
        tests++;
        if (dout !== 2'b10) begin
            fails++;
            $display("FAIL hold_code: dout=%b, want 10", dout);
        end
        repeat (3) cyc(1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_glitch[%0d]: dout=%b reject=%b busy=%b, want 00 0 1", i, dout, reject, busy);
            end
        end
        for (int k = 1; k <= GAP; k++) begin
            cyc(1'b0);
            tests++;
            if (dout !== 2'b00 || reject !== 1'b0 || busy !== (k < GAP)) begin
                fails++;
                $display("FAIL hold_restart[%0d]: dout=%b reject=%b busy=%b, want 00 0 %b", k, dout, reject, busy, k < GAP);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (12) cyc(1'b1);
        rst = 1'b1;
        cyc(1'b1);
        tests++;
        if (dout !== 2'b00 || reject !== 1'b0 || jam !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_measure: dout=%b reject=%b jam=%b busy=%b, want 00 0 0 0", dout, reject, jam, busy);
        end
        rst = 1'b0;
        cyc(1'b0);
        tests++;
        if (dout !== 2'b00 || reject !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_discard: dout=%b reject=%b busy=%b, want 00 0 0", dout, reject, busy);
        end
        repeat (20) cyc(1'b1);
        cyc(1'b0);
        tests++;
        if (dout !== 2'b11 || reject !== 1'b0) begin
            fails++;
            $display("FAIL rst_fresh_code: dout=%b reject=%b, want 11 0", dout, reject);
        end
        cyc(1'b0);
        tests++;
        if (dout !== 2'b00) begin
            fails++;
            $display("FAIL rst_fresh_once: dout=%b, want 00", dout);
        end
        repeat (GAP) cyc(1'b0);
        repeat (45) cyc(1'b1);
        tests++;
        if (jam !== 1'b1) begin
            fails++;
            $display("FAIL rst_jam_pre: jam=%b, want 1", jam);
        end
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
        tests++;
        if (jam !== 1'b0 || reject !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_jam: jam=%b reject=%b busy=%b, want 0 0 0", jam, reject, busy);
        end
        repeat (5) cyc(1'b1);
        cyc(1'b0);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || dout !== 2'b00) begin
            fails++;
            $display("FAIL rst_hold: busy=%b dout=%b, want 0 00", busy, dout);
        end
    endtask

    task automatic test_back_to_back();
        repeat (20) cyc(1'b1);
        cyc(1'b0);
        tests++;
        if (dout !== 2'b11) begin
            fails++;
            $display("FAIL b2b_first: dout=%b, want 11", dout);
        end
        repeat (GAP) cyc(1'b0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
        repeat (5) cyc(1'b1);
        cyc(1'b0);
        tests++;
        if (dout !== 2'b10 || reject !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: dout=%b reject=%b, want 10 0", dout, reject);
        end
        repeat (GAP + 1) cyc(1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        coin_in = 1'b0;
        test_reset();
        test_five_unit();
        test_widths();
        test_reject();
        test_jam();
        test_hold_restart();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
